// File: rtl/mcu_led_seq_pkg.sv
// rtl/mcu_led_seq_pkg.sv - register map, bit positions and FSM states for the LED sequencer
package mcu_led_seq_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PERIOD   = 3'd1;
    localparam logic [2:0] REG_PAT_IDX  = 3'd2;
    localparam logic [2:0] REG_PAT_DATA = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_LOOP_BIT  = 1;
    localparam int CTRL_LEN_LSB   = 4;
    localparam int CTRL_LEN_MSB   = 6;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_STEP_LSB  = 8;
    localparam int STAT_STEP_MSB  = 11;
    localparam int STAT_WRAPS_LSB = 16;
    localparam int STAT_WRAPS_MSB = 31;

    // Shortest step: one write cycle plus one wait cycle.
    localparam int PERIOD_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mcu_led_seq_if.sv
// rtl/mcu_led_seq_if.sv - CPU-side Avalon-MM slave and PIO-side Avalon-MM master signals
interface mcu_led_seq_if;
    logic [2:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    // Sequencer's view: CPU slave port plus PIO master port.
    modport slave (
        input  s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        output s_readdata, m_address, m_write_n, m_writedata
    );

    // Environment's view: the CPU and the PIO together.
    modport master (
        output s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        input  s_readdata, m_address, m_write_n, m_writedata
    );
endinterface

// File: rtl/mcu_led_seq_timer.sv
// rtl/mcu_led_seq_timer.sv - loadable down-counter timing the gap between LED writes
module mcu_led_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload wins over counting; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle in which the count steps down to zero, so a load of
    // N yields N enabled cycles before the flag is acted upon.
    assign zero = en && (cnt_q <= W'(1));

endmodule

// File: rtl/mcu_led_seq.sv
// rtl/mcu_led_seq.sv - LED pattern sequencer top; optional irq under MCU_LED_SEQ_IRQ_EN
module mcu_led_seq
    import mcu_led_seq_pkg::*;
#(
    parameter int                PAT_DEPTH  = 8,
    parameter int                PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(5_000_000)
) (
    input  logic          clk,
    input  logic          reset,
    mcu_led_seq_if.slave  bus
`ifdef MCU_LED_SEQ_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int         IDX_W    = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
    localparam logic [3:0] MAX_STEP = 4'(PAT_DEPTH - 1);

    // CPU-visible registers
    logic                 en_q, en_d;
    logic                 loop_q, loop_d;
    logic [2:0]           len_m1_q, len_m1_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [IDX_W-1:0]     pat_idx_q, pat_idx_d;
    logic [PAT_DEPTH-1:0] pattern_q, pattern_d;
    logic                 done_q, done_d;
    logic [15:0]          wraps_q, wraps_d;

    // FSM state and registered master outputs
    seq_state_e           state_q;
    logic [IDX_W-1:0]     step_q;
    logic                 m_write_n_q;
    logic                 led_q;

    logic                 wr_en;
    logic                 done_clr;
    logic [3:0]           last_step;
    logic                 is_last;
    logic                 xfer_done;
    logic                 go_wait;
    logic                 ev_wrap;
    logic                 ev_done;
    logic                 tmr_zero;
    logic [31:0]          rdata;
    logic                 unused_wdata;

    assign wr_en    = bus.s_chipselect && !bus.s_write_n;
    assign done_clr = wr_en && (bus.s_address == REG_STATUS) && bus.s_writedata[STAT_DONE_BIT];

    // Last step index, with the programmed length saturated to the table size.
    always_comb begin
        last_step = ({1'b0, len_m1_q} > MAX_STEP) ? MAX_STEP : {1'b0, len_m1_q};
        is_last   = (4'(step_q) == last_step);
    end

    // Sequencer events at the completion edge of a master write.
    assign xfer_done = (state_q == ST_WRITE) && !bus.m_waitrequest;
    assign go_wait   = xfer_done && en_q && (!is_last || loop_q);
    assign ev_wrap   = xfer_done && en_q && is_last && loop_q;
    assign ev_done   = xfer_done && en_q && is_last && !loop_q;

    mcu_led_seq_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (go_wait),
        .en       (state_q == ST_WAIT),
        .load_val (period_q - PERIOD_W'(1)),
        .zero     (tmr_zero)
    );

    // Register file next state: FSM side effects first, CPU writes override.
    always_comb begin
        en_d      = en_q;
        loop_d    = loop_q;
        len_m1_d  = len_m1_q;
        period_d  = period_q;
        pat_idx_d = pat_idx_q;
        pattern_d = pattern_q;
        done_d    = done_q;
        wraps_d   = wraps_q;

        if (ev_wrap) begin
            wraps_d = wraps_q + 16'd1;
        end
        if (done_clr) begin
            done_d = 1'b0;
        end
        if (ev_done) begin
            en_d   = 1'b0;
            done_d = 1'b1;
        end

        if (wr_en) begin
            case (bus.s_address)
                REG_CTRL: begin
                    en_d     = bus.s_writedata[CTRL_EN_BIT];
                    loop_d   = bus.s_writedata[CTRL_LOOP_BIT];
                    len_m1_d = bus.s_writedata[CTRL_LEN_MSB:CTRL_LEN_LSB];
                end
                REG_PERIOD: begin
                    period_d = (bus.s_writedata[PERIOD_W-1:0] < PERIOD_W'(PERIOD_MIN))
                             ? PERIOD_W'(PERIOD_MIN) : bus.s_writedata[PERIOD_W-1:0];
                end
                REG_PAT_IDX: begin
                    pat_idx_d = bus.s_writedata[IDX_W-1:0];
                end
                REG_PAT_DATA: begin
                    pattern_d[pat_idx_q] = bus.s_writedata[0];
                    pat_idx_d            = pat_idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Register file state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            loop_q    <= 1'b0;
            len_m1_q  <= '0;
            period_q  <= PERIOD_RST;
            pat_idx_q <= '0;
            pattern_q <= '0;
            done_q    <= 1'b0;
            wraps_q   <= '0;
        end else begin
            en_q      <= en_d;
            loop_q    <= loop_d;
            len_m1_q  <= len_m1_d;
            period_q  <= period_d;
            pat_idx_q <= pat_idx_d;
            pattern_q <= pattern_d;
            done_q    <= done_d;
            wraps_q   <= wraps_d;
        end
    end

    // Sequencer FSM with registered master strobe and LED data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            m_write_n_q <= 1'b1;
            led_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q) begin
                        state_q     <= ST_WRITE;
                        step_q      <= '0;
                        m_write_n_q <= 1'b0;
                        led_q       <= pattern_q[0];
                    end
                end
                ST_WRITE: begin
                    // A started transfer always finishes, even if EN dropped.
                    if (!bus.m_waitrequest) begin
                        m_write_n_q <= 1'b1;
                        if (go_wait) begin
                            state_q <= ST_WAIT;
                            step_q  <= is_last ? '0 : step_q + IDX_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!en_q) begin
                        state_q <= ST_IDLE;
                    end else if (tmr_zero) begin
                        state_q     <= ST_WRITE;
                        m_write_n_q <= 1'b0;
                        led_q       <= pattern_q[step_q];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency register read, decoded from the address alone.
    always_comb begin
        rdata = '0;
        case (bus.s_address)
            REG_CTRL: begin
                rdata[CTRL_EN_BIT]                 = en_q;
                rdata[CTRL_LOOP_BIT]               = loop_q;
                rdata[CTRL_LEN_MSB:CTRL_LEN_LSB]   = len_m1_q;
            end
            REG_PERIOD:   rdata[PERIOD_W-1:0] = period_q;
            REG_PAT_IDX:  rdata[IDX_W-1:0]    = pat_idx_q;
            REG_PAT_DATA: rdata[0]            = pattern_q[pat_idx_q];
            REG_STATUS: begin
                rdata[STAT_BUSY_BIT]                 = (state_q != ST_IDLE);
                rdata[STAT_DONE_BIT]                 = done_q;
                rdata[STAT_STEP_MSB:STAT_STEP_LSB]   = 4'(step_q);
                rdata[STAT_WRAPS_MSB:STAT_WRAPS_LSB] = wraps_q;
            end
            default: ;
        endcase
    end

    assign bus.s_readdata  = rdata;
    assign bus.m_address   = 2'b00;
    assign bus.m_write_n   = m_write_n_q;
    assign bus.m_writedata = {31'b0, led_q};

    // Upper write-data bits carry no register fields.
    assign unused_wdata = ^bus.s_writedata;

`ifdef MCU_LED_SEQ_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt: raised on completion or wrap, cleared with DONE; raise wins.
    always_comb begin
        irq_d = irq_q;
        if (done_clr) begin
            irq_d = 1'b0;
        end
        if (ev_done || ev_wrap) begin
            irq_d = 1'b1;
        end
    end

    // Interrupt state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mcu_led_seq.sv
// tb/tb_mcu_led_seq.sv - directed self-checking bench for mcu_led_seq
module tb_mcu_led_seq;
    import mcu_led_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcu_led_seq_if bus();
`ifdef MCU_LED_SEQ_IRQ_EN
    logic irq;
`endif

    mcu_led_seq #(
        .PAT_DEPTH  (8),
        .PERIOD_W   (24),
        .PERIOD_RST (24'd5_000_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MCU_LED_SEQ_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe monitor: start cycle, data and low-time of each master write.
    int          cyc = 0;
    int          n_st = 0;
    int          n_len = 0;
    int          run = 0;
    int          unstable = 0;
    int          st_cyc [256];
    logic [31:0] st_dat [256];
    int          st_len [256];
    logic        prev_wn = 1'b1;
    logic [31:0] prev_dat = '0;

    always @(negedge clk) begin
        cyc++;
        if (bus.m_write_n === 1'b0) begin
            if (prev_wn) begin
                if (n_st < 256) begin
                    st_cyc[n_st] = cyc;
                    st_dat[n_st] = bus.m_writedata;
                end
                n_st++;
                run = 1;
            end else begin
                run++;
                if (bus.m_writedata !== prev_dat) unstable++;
            end
        end else if (!prev_wn) begin
            if (n_len < 256) st_len[n_len] = run;
            n_len++;
        end
        prev_wn  = (bus.m_write_n !== 1'b0);
        prev_dat = bus.m_writedata;
    end

    task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(negedge clk);
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] mask,
                             input logic [31:0] exp);
        logic [31:0] d;
        bus.s_address    = a;
        bus.s_chipselect = 1'b1;
        #1;
        d = bus.s_readdata;
        bus.s_chipselect = 1'b0;
        check_val(tag, d & mask, exp);
    endtask

    // Returns at negedge+1 of the first cycle of the next write strobe.
    task automatic wait_strobe(input string tag);
        int  i;
        bit  seen_hi;
        seen_hi = (bus.m_write_n === 1'b1);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (bus.m_write_n === 1'b1) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        check_val({tag, "_seen"}, 32'(i < 200), 32'd1);
    endtask

    task automatic wait_count(input string tag, input int target);
        int i;
        for (i = 0; i < 400 && n_st < target; i++) @(negedge clk);
        #1;
        check_val({tag, "_count"}, 32'(n_st >= target), 32'd1);
    endtask

    logic [31:0] pat [4] = '{32'd1, 32'd0, 32'd1, 32'd1};
    int base, base_len, b4;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.s_address     = '0;
        bus.s_chipselect  = 1'b0;
        bus.s_write_n     = 1'b1;
        bus.s_writedata   = '0;
        bus.m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        check_reg("rst_ctrl",   REG_CTRL,   32'hFFFF_FFFF, 32'h0);
        check_reg("rst_period", REG_PERIOD, 32'hFFFF_FFFF, 32'd5_000_000);
        check_reg("rst_status", REG_STATUS, 32'hFFFF_FFFF, 32'h0);
        check_val("rst_wn",   {31'b0, bus.m_write_n}, 32'd1);
        check_val("rst_data", bus.m_writedata, 32'h0);
        check_val("rst_addr", {30'b0, bus.m_address}, 32'h0);

        // Unmapped offset reads 0 and its write changes nothing
        cpu_wr(3'd6, 32'hFFFF_FFFF);
        check_reg("unmapped_rd", 3'd6, 32'hFFFF_FFFF, 32'h0);
        check_reg("unmapped_ctrl", REG_CTRL, 32'hFFFF_FFFF, 32'h0);

        // Pattern table {1,0,1,1}
        cpu_wr(REG_PAT_IDX, 32'd0);
        for (int k = 0; k < 4; k++) cpu_wr(REG_PAT_DATA, pat[k]);
        check_reg("pat_idx_inc", REG_PAT_IDX, 32'hFFFF_FFFF, 32'd4);
        cpu_wr(REG_PAT_IDX, 32'd1);
        check_reg("pat_rd1", REG_PAT_DATA, 32'hFFFF_FFFF, 32'd0);
        cpu_wr(REG_PAT_IDX, 32'd0);
        check_reg("pat_rd0", REG_PAT_DATA, 32'hFFFF_FFFF, 32'd1);
        cpu_wr(REG_PERIOD, 32'd4);

        // One-shot, LEN=4, PERIOD=4
        base = n_st; base_len = n_len;
        cpu_wr(REG_CTRL, 32'h31);
        #1;
        check_val("t1_pre_low", {31'b0, bus.m_write_n}, 32'd1);
        @(negedge clk);
        #1;
        check_val("t1_first_low", {31'b0, bus.m_write_n}, 32'd0);
        check_val("t1_first_dat", bus.m_writedata, 32'd1);
        wait_count("t1", base + 4);
        repeat (20) @(negedge clk);
        #1;
        check_val("t1_total", 32'(n_st - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_val("t1_dat", st_dat[base + k], pat[k]);
            check_val("t1_len", 32'(st_len[base_len + k]), 32'd1);
        end
        for (int k = 1; k < 4; k++)
            check_val("t1_gap", 32'(st_cyc[base + k] - st_cyc[base + k - 1]), 32'd4);
        check_reg("t1_status", REG_STATUS, 32'h3, 32'h2);
        check_reg("t1_ctrl",   REG_CTRL,   32'h73, 32'h30);
`ifdef MCU_LED_SEQ_IRQ_EN
        check_val("t1_irq", {31'b0, irq}, 32'd1);
        cpu_wr(REG_STATUS, 32'h2);
        #1;
        check_val("t1_irq_clr", {31'b0, irq}, 32'd0);
`endif

        // Looping, 3 laps
        cpu_wr(REG_STATUS, 32'h2);
        check_reg("t2_done_clr", REG_STATUS, 32'h3, 32'h0);
        base = n_st;
        cpu_wr(REG_CTRL, 32'h33);
        wait_count("t2", base + 13);
        check_reg("t2_wraps", REG_STATUS, 32'hFFFF_0003, 32'h0003_0001);
        for (int k = 0; k < 13; k++) check_val("t2_dat", st_dat[base + k], pat[k % 4]);
        for (int k = 1; k < 13; k++)
            check_val("t2_gap", 32'(st_cyc[base + k] - st_cyc[base + k - 1]), 32'd4);
        cpu_wr(REG_CTRL, 32'h0);
        repeat (10) @(negedge clk);
        #1;
        check_reg("t2_stop", REG_STATUS, 32'h3, 32'h0);

        // Wait states on step 1
        base = n_st; base_len = n_len; unstable = 0;
        cpu_wr(REG_CTRL, 32'h31);
        wait_strobe("t3_s0");
        @(negedge clk);
        bus.m_waitrequest = 1'b1;
        wait_strobe("t3_s1");
        repeat (5) @(negedge clk);
        bus.m_waitrequest = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check_val("t3_total", 32'(n_st - base), 32'd4);
        check_val("t3_len1", 32'(st_len[base_len + 1]), 32'd6);
        check_val("t3_dat1", st_dat[base + 1], 32'd0);
        check_val("t3_stable", 32'(unstable), 32'd0);
        check_val("t3_gap01", 32'(st_cyc[base + 1] - st_cyc[base]), 32'd4);
        check_val("t3_gap12", 32'(st_cyc[base + 2] - st_cyc[base + 1]), 32'd9);
        check_val("t3_gap23", 32'(st_cyc[base + 3] - st_cyc[base + 2]), 32'd4);
        cpu_wr(REG_STATUS, 32'h2);

        // EN cleared during a stalled write, then restart from step 0
        cpu_wr(REG_CTRL, 32'h33);
        wait_strobe("t4_s0");
        wait_strobe("t4_s1");
        @(negedge clk);
        bus.m_waitrequest = 1'b1;
        wait_strobe("t4_s2");
        cpu_wr(REG_CTRL, 32'h32);
        #1;
        check_val("t4_inflight", {31'b0, bus.m_write_n}, 32'd0);
        repeat (2) @(negedge clk);
        bus.m_waitrequest = 1'b0;
        @(negedge clk);
        #1;
        check_val("t4_completed", {31'b0, bus.m_write_n}, 32'd1);
        b4 = n_st;
        repeat (15) @(negedge clk);
        #1;
        check_val("t4_no_more", 32'(n_st - b4), 32'd0);
        check_reg("t4_status", REG_STATUS, 32'h3, 32'h0);
        cpu_wr(REG_CTRL, 32'h33);
        wait_strobe("t4_r0");
        check_val("t4_r0_dat", bus.m_writedata, 32'd1);
        check_reg("t4_r0_step", REG_STATUS, 32'h0F00, 32'h0000);
        wait_strobe("t4_r1");
        check_val("t4_r1_dat", bus.m_writedata, 32'd0);
        check_reg("t4_r1_step", REG_STATUS, 32'h0F00, 32'h0100);
        cpu_wr(REG_CTRL, 32'h0);
        repeat (15) @(negedge clk);

`ifdef MCU_LED_SEQ_IRQ_EN
        // Clear coinciding with a wrap: irq stays set
        cpu_wr(REG_STATUS, 32'h2);
        #1;
        check_val("irq_pre_clr", {31'b0, irq}, 32'd0);
        cpu_wr(REG_CTRL, 32'h33);
        wait_strobe("irq_s0");
        wait_strobe("irq_s1");
        wait_strobe("irq_s2");
        @(negedge clk);
        bus.m_waitrequest = 1'b1;
        wait_strobe("irq_s3");
        check_val("irq_before_wrap", {31'b0, irq}, 32'd0);
        @(negedge clk);
        bus.m_waitrequest = 1'b0;
        bus.s_address     = REG_STATUS;
        bus.s_writedata   = 32'h2;
        bus.s_chipselect  = 1'b1;
        bus.s_write_n     = 1'b0;
        @(negedge clk);
        bus.s_chipselect  = 1'b0;
        bus.s_write_n     = 1'b1;
        #1;
        check_val("irq_set_wins", {31'b0, irq}, 32'd1);
        cpu_wr(REG_CTRL, 32'h0);
        repeat (15) @(negedge clk);
        cpu_wr(REG_STATUS, 32'h2);
        #1;
        check_val("irq_final_clr", {31'b0, irq}, 32'd0);
`endif

        // PERIOD below minimum is clamped to 2
        cpu_wr(REG_PERIOD, 32'd0);
        check_reg("t5_clamp", REG_PERIOD, 32'hFFFF_FFFF, 32'd2);
        base = n_st;
        cpu_wr(REG_CTRL, 32'h31);
        wait_count("t5", base + 4);
        for (int k = 1; k < 4; k++)
            check_val("t5_gap", 32'(st_cyc[base + k] - st_cyc[base + k - 1]), 32'd2);
        repeat (10) @(negedge clk);

        // Reset in the middle of a stalled write
        bus.m_waitrequest = 1'b1;
        cpu_wr(REG_CTRL, 32'h31);
        wait_strobe("t6_s0");
        reset = 1'b1;
        #1;
        check_val("t6_async_wn", {31'b0, bus.m_write_n}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.m_waitrequest = 1'b0;
        #1;
        check_reg("t6_ctrl",    REG_CTRL,     32'hFFFF_FFFF, 32'h0);
        check_reg("t6_period",  REG_PERIOD,   32'hFFFF_FFFF, 32'd5_000_000);
        check_reg("t6_pat_idx", REG_PAT_IDX,  32'hFFFF_FFFF, 32'h0);
        check_reg("t6_pat0",    REG_PAT_DATA, 32'hFFFF_FFFF, 32'h0);
        check_reg("t6_status",  REG_STATUS,   32'hFFFF_FFFF, 32'h0);
        check_val("t6_data", bus.m_writedata, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        check_val("t6_idle_wn", {31'b0, bus.m_write_n}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
